// File: rtl/line_mem_arbiter_pkg.sv
// Shared constants for the I/D line-memory arbiter and the caches above it.
// State and grant encodings, line geometry and the default memory latency.
package line_mem_arbiter_pkg;

    localparam int DEFAULT_LATENCY = 4;
    localparam int WORD_W          = 16;
    localparam int LINE_W          = 64;
    localparam int LINE_WORDS      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

endpackage

// File: rtl/line_mem_arbiter_if.sv
// Cache-side request/response and memory-side command signals of the arbiter.
// master: the arbiter itself; slave: caches plus memory model around it.
interface line_mem_arbiter_if #(
    parameter int WORD = 16,
    parameter int LINE = 64
);
    logic            i_readM;
    logic [WORD-1:0] i_address;
    logic [LINE-1:0] i_rdata;
    logic            i_ready;

    logic            d_readM;
    logic            d_writeM;
    logic [WORD-1:0] d_address;
    logic [LINE-1:0] d_wdata;
    logic [LINE-1:0] d_rdata;
    logic            d_ready;

    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] mem_address;
    logic [LINE-1:0] mem_wdata;
    logic [LINE-1:0] mem_rdata;

    modport master (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/line_mem_arbiter_latency_counter.sv
// Memory access timer: start arms it, done is high in the LATENCY-th cycle after.
// No backpressure; a new start restarts the count from zero.
module mem_latency_counter
    import line_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int             CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LATENCY - 1);

    logic [CW-1:0] count;
    logic          running;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            // Park on LAST so the count never wraps inside a transaction.
            if (count == LAST) running <= 1'b0;
            else               count   <= count + 1'b1;
        end
    end

    assign done = running && (count == LAST);

endmodule

// File: rtl/line_mem_arbiter.sv
// I/D cache arbiter for one line-wide memory port; LATENCY+1 cycles request to ready pulse.
// Requests held by the caches until ready; LINE_ARB_ROUND_ROBIN_EN selects round-robin ties, else D priority.
module line_mem_arbiter
    import line_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int WORD    = WORD_W,
    parameter int LINE    = LINE_W
) (
    input  logic               clk,
    input  logic               reset,
    line_mem_arbiter_if.master bus
);
    arb_state_t state, state_nxt;
    arb_gnt_t   gnt;
    logic       i_req, d_req, pick_d, load, cnt_done;

    mem_latency_counter #(.LATENCY(LATENCY)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .done  (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        bus.i_ready = 1'b0;
        bus.d_ready = 1'b0;
        i_req       = bus.i_readM;
        d_req       = bus.d_readM | bus.d_writeM;
`ifdef LINE_ARB_ROUND_ROBIN_EN
        // gnt still holds the previous winner, so a tie goes to the other side.
        pick_d      = d_req && (!i_req || (gnt == GNT_I));
`else
        pick_d      = d_req;
`endif
        case (state)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    load      = 1'b1;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (cnt_done) state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                bus.i_ready = (gnt == GNT_I);
                bus.d_ready = (gnt == GNT_D);
                state_nxt   = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt             <= GNT_I;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            bus.i_rdata     <= '0;
            bus.d_rdata     <= '0;
        end else begin
            if (load) begin
                gnt             <= pick_d ? GNT_D : GNT_I;
                // A D request with both strobes high is a write.
                bus.mem_read    <= !(pick_d && bus.d_writeM);
                bus.mem_write   <= pick_d && bus.d_writeM;
                bus.mem_address <= (pick_d ? bus.d_address : bus.i_address)
                                   & ~WORD'(LINE_WORDS - 1);
                if (pick_d) bus.mem_wdata <= LINE'(bus.d_wdata);
            end
            if (cnt_done) begin
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
                if (bus.mem_read) begin
                    if (gnt == GNT_D) bus.d_rdata <= bus.mem_rdata;
                    else              bus.i_rdata <= bus.mem_rdata;
                end
            end
        end
    end

endmodule
